// File: rtl/rng_pkg.sv
// Shared types, default constants and the Galois step function for the ball-outcome RNG.
package rng_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        RETRY = 1'b1
    } rng_state_e;

    // Widest LFSR the shared step function supports; narrower callers zero-extend.
    localparam int RNG_MAX_W = 64;

    localparam logic [15:0] RNG_DEF_TAPS     = 16'hB400;
    localparam logic [15:0] RNG_DEF_SEED     = 16'hACE1;
    localparam logic [15:0] RNG_DEF_SEED_ALT = 16'h9263;

    function automatic logic [RNG_MAX_W-1:0] lfsr_next(
        input logic [RNG_MAX_W-1:0] state,
        input logic [RNG_MAX_W-1:0] taps,
        input logic [RNG_MAX_W-1:0] seed
    );
        logic [RNG_MAX_W-1:0] nxt;
        nxt = (state >> 1) ^ (state[0] ? taps : '0);
        return (nxt == '0) ? seed : nxt;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR with lock-up recovery, external load and periodic reseed mixing.
// Priority: clear > load > reseed > plain advance.
module lfsr_galois
    import rng_pkg::*;
#(
    parameter int unsigned       LFSR_W   = 16,
    parameter logic [LFSR_W-1:0] TAPS     = LFSR_W'(RNG_DEF_TAPS),
    parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(RNG_DEF_SEED),
    parameter logic [LFSR_W-1:0] SEED_ALT = LFSR_W'(RNG_DEF_SEED_ALT)
) (
    input  logic              clk,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_val_i,
    input  logic              reseed_i,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] adv;
    logic [LFSR_W-1:0] mixed;

    always_comb begin
        adv   = LFSR_W'(lfsr_next(RNG_MAX_W'(lfsr_q), RNG_MAX_W'(TAPS), RNG_MAX_W'(SEED)));
        mixed = adv ^ SEED_ALT;
        // NOTE: default assignment first so every path drives lfsr_d and no latch is inferred.
        lfsr_d = adv;
        if (load_i) begin
            lfsr_d = (load_val_i == '0) ? SEED : load_val_i;
        end else if (reseed_i) begin
            lfsr_d = (mixed == '0) ? SEED : mixed;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples pre-edge values regardless of process order.
        if (clear_i) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/ball_outcome_rng.sv
// Ball-outcome generator: rejection sampling over an LFSR with bounded retries and fold fallback.
// Optional `RNG_SEED_LOAD_EN adds seed_load/seed_in for run-time reseeding.
module ball_outcome_rng
    import rng_pkg::*;
#(
    parameter int unsigned       LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] TAPS          = LFSR_W'(RNG_DEF_TAPS),
    parameter logic [LFSR_W-1:0] SEED          = LFSR_W'(RNG_DEF_SEED),
    parameter logic [LFSR_W-1:0] SEED_ALT      = LFSR_W'(RNG_DEF_SEED_ALT),
    parameter int unsigned       OUT_W         = 4,
    parameter int unsigned       MAX_VAL       = 8,
    parameter int unsigned       MAX_RETRY     = 3,
    parameter int unsigned       RESEED_PERIOD = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              game_over,
    input  logic              ball_req,
`ifdef RNG_SEED_LOAD_EN
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
`endif
    output logic              out_valid,
    output logic [OUT_W-1:0]  outcome,
    output logic              busy,
    output logic              req_overrun,
    output logic [LFSR_W-1:0] lfsr_state
);

    localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int DC_W = $clog2(RESEED_PERIOD + 1);
    localparam logic [OUT_W-1:0] MAX_V   = OUT_W'(MAX_VAL);
    localparam logic [OUT_W-1:0] RANGE_V = OUT_W'(MAX_VAL + 1);

    rng_state_e        state_q, state_d;
    logic [RC_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic [DC_W-1:0]   draw_cnt_q;
    logic [OUT_W-1:0]  outcome_q;
    logic              out_valid_q;
    logic              req_overrun_q;

    logic              clear;
    logic              load;
    logic [LFSR_W-1:0] load_val;
    logic              deliver;
    logic              reseed;
    logic              overrun_d;
    logic [LFSR_W-1:0] lfsr_q;
    logic [OUT_W-1:0]  cand;
    logic              cand_ok;
    logic [OUT_W-1:0]  fold;

    assign clear = rst | game_over;

`ifdef RNG_SEED_LOAD_EN
    assign load     = seed_load;
    assign load_val = seed_in;
`else
    assign load     = 1'b0;
    assign load_val = '0;
`endif

    lfsr_galois #(
        .LFSR_W   (LFSR_W),
        .TAPS     (TAPS),
        .SEED     (SEED),
        .SEED_ALT (SEED_ALT)
    ) u_lfsr (
        .clk        (clk),
        .clear_i    (clear),
        .load_i     (load),
        .load_val_i (load_val),
        .reseed_i   (reseed),
        .lfsr_o     (lfsr_q)
    );

    // fold equals cand whenever cand is already legal, so it doubles as the delivered value.
    assign cand    = lfsr_q[OUT_W-1:0] ^ lfsr_q[2*OUT_W-1:OUT_W];
    assign cand_ok = (cand <= MAX_V);
    assign fold    = cand_ok ? cand : cand - RANGE_V;

    assign reseed = deliver && (draw_cnt_q == DC_W'(RESEED_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (clear || load) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        deliver     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ball_req) begin
                    if (cand_ok || (MAX_RETRY == 0)) begin
                        deliver = 1'b1;
                    end else begin
                        state_d     = RETRY;
                        retry_cnt_d = RC_W'(1);
                    end
                end
            end
            RETRY: begin
                if (cand_ok || (retry_cnt_q == RC_W'(MAX_RETRY))) begin
                    deliver     = 1'b1;
                    state_d     = IDLE;
                    retry_cnt_d = '0;
                end else begin
                    retry_cnt_d = retry_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                retry_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        busy      = (state_q == RETRY);
        overrun_d = ball_req && (state_q == RETRY);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            retry_cnt_q   <= '0;
            draw_cnt_q    <= '0;
            outcome_q     <= '0;
            out_valid_q   <= 1'b0;
            req_overrun_q <= 1'b0;
        end else if (load) begin
            retry_cnt_q   <= '0;
            draw_cnt_q    <= '0;
            out_valid_q   <= 1'b0;
            req_overrun_q <= 1'b0;
        end else begin
            retry_cnt_q   <= retry_cnt_d;
            out_valid_q   <= deliver;
            req_overrun_q <= overrun_d;
            if (deliver) begin
                outcome_q  <= fold;
                draw_cnt_q <= reseed ? '0 : draw_cnt_q + 1'b1;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign outcome     = outcome_q;
    assign req_overrun = req_overrun_q;
    assign lfsr_state  = lfsr_q;

endmodule

// File: tb/tb_ball_outcome_rng.sv
// Self-checking bench for ball_outcome_rng: directed vectors plus a reference model feeding a scoreboard.
module tb_ball_outcome_rng;

    localparam logic [15:0] SEED   = 16'hACE1;
    localparam logic [15:0] TAPS   = 16'hB400;
    localparam logic [15:0] ALT    = 16'h9263;
    localparam logic [15:0] SEED2  = 16'h00C0;
    localparam int          MAXV   = 8;
    localparam int          MAXR   = 3;
    localparam int          PERIOD = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        game_over = 1'b0;
    logic        ball_req = 1'b0;
    logic        ball_req2 = 1'b0;
`ifdef RNG_SEED_LOAD_EN
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0;
`endif

    logic        out_valid, busy, req_overrun;
    logic [3:0]  outcome;
    logic [15:0] lfsr_state;
    logic        out_valid2, busy2, req_overrun2;
    logic [3:0]  outcome2;
    logic [15:0] lfsr_state2;

    ball_outcome_rng dut (
        .clk         (clk),
        .rst         (rst),
        .game_over   (game_over),
        .ball_req    (ball_req),
`ifdef RNG_SEED_LOAD_EN
        .seed_load   (seed_load),
        .seed_in     (seed_in),
`endif
        .out_valid   (out_valid),
        .outcome     (outcome),
        .busy        (busy),
        .req_overrun (req_overrun),
        .lfsr_state  (lfsr_state)
    );

    ball_outcome_rng #(.MAX_RETRY(0), .SEED(SEED2)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .game_over   (game_over),
        .ball_req    (ball_req2),
`ifdef RNG_SEED_LOAD_EN
        .seed_load   (1'b0),
        .seed_in     (16'h0),
`endif
        .out_valid   (out_valid2),
        .outcome     (outcome2),
        .busy        (busy2),
        .req_overrun (req_overrun2),
        .lfsr_state  (lfsr_state2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] m_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]} ^ (s[0] ? TAPS : 16'h0);
        return (n == 16'h0) ? SEED : n;
    endfunction

    typedef struct {
        logic [3:0] val;
        int         due;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state, advanced on every rising edge from the bench-driven inputs.
    logic [15:0] m_lfsr = SEED;
    logic [15:0] m_nxt;
    logic [3:0]  m_outcome = 4'h0;
    bit          m_busy = 1'b0;
    bit          m_overrun = 1'b0;
    bit          m_dlv;
    int          m_cnt = 0;
    int          m_draw = 0;
    int          m_cand, m_fold;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            m_overrun = 1'b0;
            if (rst || game_over) begin
                m_lfsr = SEED; m_busy = 1'b0; m_cnt = 0; m_draw = 0; m_outcome = 4'h0;
`ifdef RNG_SEED_LOAD_EN
            end else if (seed_load) begin
                m_lfsr = (seed_in == 16'h0) ? SEED : seed_in;
                m_busy = 1'b0; m_cnt = 0; m_draw = 0;
`endif
            end else begin
                m_cand = int'(m_lfsr[3:0] ^ m_lfsr[7:4]);
                m_fold = (m_cand > MAXV) ? m_cand - (MAXV + 1) : m_cand;
                m_dlv  = 1'b0;
                if (!m_busy) begin
                    if (ball_req) begin
                        if (m_cand <= MAXV) m_dlv = 1'b1;
                        else begin m_busy = 1'b1; m_cnt = 1; end
                    end
                end else begin
                    if (ball_req) m_overrun = 1'b1;
                    if (m_cand <= MAXV || m_cnt == MAXR) m_dlv = 1'b1;
                    else m_cnt++;
                end
                m_nxt = m_step(m_lfsr);
                if (m_dlv) begin
                    m_busy = 1'b0;
                    m_cnt = 0;
                    m_outcome = 4'(m_fold);
                    exp_q.push_back('{val: 4'(m_fold), due: cyc});
                    m_draw++;
                    if (m_draw == PERIOD) begin
                        m_nxt = m_nxt ^ ALT;
                        if (m_nxt == 16'h0) m_nxt = SEED;
                        m_draw = 0;
                    end
                end
                m_lfsr = m_nxt;
            end
        end
    end

    exp_t mon_e;
    initial begin
        forever begin
            @(negedge clk);
            check("lfsr", lfsr_state, m_lfsr);
            check("busy", busy, m_busy);
            check("overrun", req_overrun, m_overrun);
            check("outcome_hold", outcome, m_outcome);
            check("lfsr_nonzero", 32'(lfsr_state != 16'h0), 1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", out_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("valid_value", outcome, mon_e.val);
                    check("valid_cycle", cyc, mon_e.due);
                end
                check("outcome_range", 32'(outcome <= 4'd8), 1);
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                check("missing_valid", out_valid, 1);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Issues one request and waits for its delivery; also checks the lfsr step taken at that delivery.
    task automatic draw_one(input int idx);
        logic [15:0] last, x;
        bit got;
        got = 1'b0;
        ball_req = 1'b1;
        last = m_lfsr;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            ball_req = 1'b0;
            if (out_valid) begin
                got = 1'b1;
                if (idx % PERIOD == 0) begin
                    x = m_step(last) ^ ALT;
                    if (x == 16'h0) x = SEED;
                    check("reseed_lfsr", lfsr_state, x);
                end else begin
                    check("plain_step_lfsr", lfsr_state, m_step(last));
                end
            end else begin
                last = m_lfsr;
            end
        end
        if (!got) check("draw_timeout", out_valid, 1);
    endtask

    initial begin
        bit done;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First draw after reset: ACE1 rejects 15, E270 yields 7; folded instance yields 3 at once.
        check("rst_lfsr", lfsr_state, 16'hACE1);
        check("rst_outcome", outcome, 4'd0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", req_overrun, 1'b0);
        check("rst_lfsr2", lfsr_state2, SEED2);
        ball_req = 1'b1; ball_req2 = 1'b1;
        @(negedge clk);
        ball_req = 1'b0; ball_req2 = 1'b0;
        check("t1_busy", busy, 1'b1);
        check("t1_valid", out_valid, 1'b0);
        check("t1_lfsr", lfsr_state, 16'hE270);
        check("fold_valid", out_valid2, 1'b1);
        check("fold_value", outcome2, 4'd3);
        check("fold_busy", busy2, 1'b0);
        check("fold_lfsr", lfsr_state2, 16'h0060);
        @(negedge clk);
        check("t2_valid", out_valid, 1'b1);
        check("t2_outcome", outcome, 4'd7);
        check("t2_busy", busy, 1'b0);
        check("fold_single", out_valid2, 1'b0);

        // Request during RETRY is dropped with a one-cycle overrun pulse.
        do_reset();
        ball_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ball_req = 1'b0;
        check("ovr_pulse", req_overrun, 1'b1);
        check("ovr_valid", out_valid, 1'b1);
        check("ovr_outcome", outcome, 4'd7);
        @(negedge clk);
        check("ovr_pulse_end", req_overrun, 1'b0);
        check("ovr_no_extra", out_valid, 1'b0);

        // game_over while a draw is retrying aborts it and clears everything.
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            ball_req = 1'b1;
            @(negedge clk);
            ball_req = 1'b0;
            if (m_busy) begin
                game_over = 1'b1;
                @(negedge clk);
                game_over = 1'b0;
                check("go_valid", out_valid, 1'b0);
                check("go_lfsr", lfsr_state, SEED);
                check("go_outcome", outcome, 4'd0);
                check("go_busy", busy, 1'b0);
                done = 1'b1;
            end
        end
        if (!done) check("go_no_retry", busy, 1'b1);

        // 45 draws span two reseeds and confirm the count restarts after each.
        do_reset();
        for (int n = 1; n <= 45; n++) draw_one(n);

`ifdef RNG_SEED_LOAD_EN
        seed_in = 16'h0; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("sl_zero", lfsr_state, SEED);
        do_reset();
        ball_req = 1'b1;
        @(negedge clk);
        ball_req = 1'b0; seed_in = 16'h5555; seed_load = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        check("sl_abort_valid", out_valid, 1'b0);
        check("sl_abort_busy", busy, 1'b0);
        check("sl_value", lfsr_state, 16'h5555);
`endif

        // Long random run; the monitor checks every cycle against the model.
        for (int i = 0; i < 24000; i++) begin
            ball_req  = 1'($urandom_range(0, 1));
            game_over = ($urandom_range(0, 999) == 0);
`ifdef RNG_SEED_LOAD_EN
            seed_load = ($urandom_range(0, 499) == 0);
            seed_in   = ($urandom_range(0, 1) == 0) ? 16'h0 : 16'($urandom);
`endif
            @(negedge clk);
        end
        ball_req = 1'b0; game_over = 1'b0;
`ifdef RNG_SEED_LOAD_EN
        seed_load = 1'b0;
`endif
        repeat (8) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
